spi_slv16: RTL and testbench
============================

SPI_SLV16 -- requirements
Module: spi_slv16

Interface
REQ-001 SHALL provide ports: clk  input  1  system clock; all logic on rising edge.
REQ-002 SHALL provide: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL provide: SS_n  input  1  slave select from master, active low, asynchronous to clk.
REQ-004 SHALL provide: SCLK  input  1  serial clock from master, idles high (CPOL=1, CPHA=1), asynchronous to clk.
REQ-005 SHALL provide: MOSI  input  1  serial data from master, MSB first.
REQ-006 SHALL provide: MISO  output  1  serial data to master, MSB first.
REQ-007 SHALL provide: tx_data  input  16  response word for the next transaction.
REQ-008 SHALL provide: wrt_tx  input  1  one-clk pulse; loads tx_data into the transmit buffer.
REQ-009 SHALL provide: rx_data  output  16  last complete word received.
REQ-010 SHALL provide: rdy  output  1  one-clk pulse when rx_data is updated.
REQ-011 SHALL provide: err  output  1  one-clk pulse when a frame ends with bit count != 16.

Function
REQ-012 SHALL pass SS_n, SCLK and MOSI through 2-flop synchronizers, plus one history flop on SS_n and SCLK for edge detection; all decisions use synchronized signals only.
REQ-013 SHALL require clk frequency >= 8x SCLK frequency; behaviour is undefined below that ratio.
REQ-014 SHALL use states IDLE, FRONT, SHIFT.
REQ-015 IDLE: on synced SS_n fall -> load shift register from transmit buffer, clear bit counter, go FRONT.
REQ-016 FRONT: ignore the first SCLK fall (master's leading edge); on SCLK rise sample MOSI into the sample flop, increment bit counter, go SHIFT.
REQ-017 SHIFT: on SCLK fall shift register left by one, LSB <- sample flop; on SCLK rise sample MOSI and increment bit counter, saturating at 31.
REQ-018 FRONT or SHIFT: on synced SS_n rise go IDLE; if counter == 16 and 16 shifts have completed -> rx_data <= shift register and rdy pulse in the same cycle, else err pulse and rx_data unchanged.
REQ-019 MISO SHALL equal shift register bit 15 while synced SS_n is low and SHALL be 0 otherwise; bit 15 of the loaded word is valid before the first SCLK rise.
REQ-020 wrt_tx SHALL update the transmit buffer at any time; an update during FRONT or SHIFT does not affect the frame in progress.
REQ-021 wrt_tx coincident with the SS_n fall cycle SHALL make the new tx_data the word that is loaded.
REQ-022 With no wrt_tx since the previous frame, the transmit buffer SHALL be re-sent unchanged.
REQ-023 SCLK edges while in IDLE SHALL be ignored.
REQ-024 SS_n pulses with no SCLK edges SHALL produce err and no rdy.
REQ-025 rdy and err SHALL be mutually exclusive and last exactly one clk.
REQ-026 Latency: rdy asserts 4 clks after the raw SS_n rise (2 synchronizer + edge-detect + state flop).

Reset
REQ-027 On rst: state IDLE, rdy=0, err=0, rx_data=0, transmit buffer=0, shift register=0, bit counter=0, MISO=0.
REQ-028 On rst: SS_n and SCLK synchronizer and history flops =1, MOSI synchronizer =0.
REQ-029 rst mid-frame SHALL abort the frame with no rdy/err; the block waits for a fresh synced SS_n fall.
REQ-030 While rst is held high, rdy, err and MISO SHALL stay 0.

Structure
REQ-031 State enum and constant FRAME_BITS=16 SHALL live in the shared package spi_pkg, alongside the master's definitions.
REQ-032 Synchronizer+edge detector SHALL be one sub-module, spi_sync_edge, instanced for SS_n and SCLK (MOSI uses its sync path only).

Verification
REQ-033 Paired with the 16-bit master (64 clk/SCLK): tx_data=16'hA5C3 then master wrt cmd=16'h1234 -> master rd_data=16'hA5C3; slave rdy once, rx_data=16'h1234.
REQ-034 Back-to-back frames with no new wrt_tx: cmd 16'hFFFF then 16'h0000 -> both master reads return the same buffer word; rx_data is 16'hFFFF then 16'h0000.
REQ-035 wrt_tx 16'hBEEF during SHIFT of a 16'h1111 frame -> this frame returns 16'h1111, next frame returns 16'hBEEF.
REQ-036 SS_n low for 8 SCLK periods then high -> err one clk, rdy 0, rx_data unchanged.
REQ-037 rst for 1 clk at bit 7 of a frame -> no rdy/err; the next full frame with cmd 16'h8001 -> rdy, rx_data=16'h8001.
REQ-038 SCLK toggling with SS_n high -> MISO=0, no rdy/err, state stays IDLE.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame size, counter widths and state encodings
// for the 16-bit slave and its companion master.
package spi_pkg;
   localparam int FRAME_BITS = 16;
   localparam int CNT_W      = 5;
   localparam int MST_SCLK_DIV = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FRONT = 2'd1,
      SHIFT = 2'd2
   } spi_state_t;

   typedef enum logic [1:0] {
      M_IDLE  = 2'd0,
      M_FRONT = 2'd1,
      M_SHIFT = 2'd2,
      M_BACK  = 2'd3
   } spi_mst_state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer plus history flop; rise/fall are registered one-clk pulses.
module spi_sync_edge #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic sync,
   output logic rise,
   output logic fall
);

   logic ff1, ff2, hist;

   always_ff @(posedge clk) begin
      if (rst) begin
         ff1  <= RST_VAL;
         ff2  <= RST_VAL;
         hist <= RST_VAL;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         ff1  <= din;
         ff2  <= ff1;
         hist <= ff2;
         rise <= ff2 & ~hist;
         fall <= ~ff2 & hist;
      end
   end

   assign sync = ff2;

endmodule

// File: rtl/spi_slv16.sv
// SPI mode-3 slave, 16-bit frames, oversampled by clk; exchanges a buffered
// response word for the master's command word.
module spi_slv16
   import spi_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        SS_n,
   input  logic        SCLK,
   input  logic        MOSI,
   output logic        MISO,
   input  logic [15:0] tx_data,
   input  logic        wrt_tx,
   output logic [15:0] rx_data,
   output logic        rdy,
   output logic        err,
   output logic [1:0]  state
);

   logic ss_sync, ss_rise, ss_fall;
   logic sclk_sync, sclk_rise, sclk_fall;
   logic mosi_ff1, mosi_sync;

   spi_sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
      .clk(clk), .rst(rst), .din(SS_n),
      .sync(ss_sync), .rise(ss_rise), .fall(ss_fall)
   );

   spi_sync_edge #(.RST_VAL(1'b1)) u_sclk_sync (
      .clk(clk), .rst(rst), .din(SCLK),
      .sync(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         mosi_ff1  <= 1'b0;
         mosi_sync <= 1'b0;
      end else begin
         mosi_ff1  <= MOSI;
         mosi_sync <= mosi_ff1;
      end
   end

   logic [15:0] tx_buf;

   always_ff @(posedge clk) begin
      if (rst)         tx_buf <= '0;
      else if (wrt_tx) tx_buf <= tx_data;
   end

   spi_state_t       state_q;
   logic [15:0]      shift_reg;
   logic [CNT_W-1:0] bit_cnt;
   logic [CNT_W-1:0] shift_cnt;
   logic             sample;
   logic [1:0]       hi_cnt;
   logic             armed;
   logic             frame_ok;

   // The last sampled bit never sees a trailing SCLK fall, so the 16th shift
   // is folded into the commit on SS_n rise.
   assign frame_ok = (bit_cnt == CNT_W'(FRAME_BITS)) &&
                     (shift_cnt == CNT_W'(FRAME_BITS - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         shift_reg <= '0;
         bit_cnt   <= '0;
         shift_cnt <= '0;
         sample    <= 1'b0;
         rx_data   <= '0;
         rdy       <= 1'b0;
         err       <= 1'b0;
         hi_cnt    <= '0;
         armed     <= 1'b0;
      end else begin
         rdy <= 1'b0;
         err <= 1'b0;
         // After reset the synchronizer starts high, so a master still holding
         // SS_n low would look like a fall; only accept falls once SS_n was seen high.
         if (!ss_sync)             hi_cnt <= '0;
         else if (hi_cnt != 2'd3)  hi_cnt <= hi_cnt + 2'd1;
         armed <= armed | (hi_cnt == 2'd3);

         if (state_q != IDLE && ss_rise) begin
            state_q <= IDLE;
            if (frame_ok) begin
               rx_data <= {shift_reg[14:0], sample};
               rdy     <= 1'b1;
            end else begin
               err <= 1'b1;
            end
         end else begin
            case (state_q)
               IDLE: begin
                  if (ss_fall && armed) begin
                     shift_reg <= wrt_tx ? tx_data : tx_buf;
                     bit_cnt   <= '0;
                     shift_cnt <= '0;
                     state_q   <= FRONT;
                  end
               end
               FRONT: begin
                  if (sclk_rise) begin
                     sample  <= mosi_sync;
                     bit_cnt <= bit_cnt + 1'b1;
                     state_q <= SHIFT;
                  end
               end
               SHIFT: begin
                  if (sclk_fall) begin
                     shift_reg <= {shift_reg[14:0], sample};
                     if (shift_cnt != '1) shift_cnt <= shift_cnt + 1'b1;
                  end
                  if (sclk_rise) begin
                     sample <= mosi_sync;
                     if (bit_cnt != '1) bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign MISO  = ~ss_sync & shift_reg[15];
   assign state = state_q;

endmodule

// File: tb/tb_spi_slv16.sv
// Bench for spi_slv16: behavioural mode-3 master (64 clk per SCLK) against a
// word-level model of the response buffer and received commands.
module tb_spi_slv16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        SS_n = 1'b1;
   logic        SCLK = 1'b1;
   logic        MOSI = 1'b0;
   logic        MISO;
   logic [15:0] tx_data = '0;
   logic        wrt_tx = 1'b0;
   logic [15:0] rx_data;
   logic        rdy;
   logic        err;
   logic [1:0]  state;

   int n_cmp = 0;
   int n_bad = 0;

   spi_slv16 dut (
      .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
      .tx_data(tx_data), .wrt_tx(wrt_tx), .rx_data(rx_data), .rdy(rdy),
      .err(err), .state(state)
   );

   always #5 clk = ~clk;

   // Reference model: response buffer contents and last good command word.
   logic [15:0] tx_model = '0;
   logic [15:0] rx_model = '0;
   logic [15:0] exp_q[$];

   int   rdy_cnt = 0;
   int   err_cnt = 0;
   int   viol = 0;
   logic rdy_prev = 1'b0;
   logic err_prev = 1'b0;

   always @(negedge clk) begin
      if (rdy) begin
         rdy_cnt++;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_rdy: rx_data=%h with no frame expected", rx_data);
         end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            if (rx_data !== e) begin
               n_bad++;
               $display("FAIL rx_word: got %h expected %h", rx_data, e);
            end
         end
      end
      if (err) err_cnt++;
      if (rdy && err) viol++;
      if ((rdy && rdy_prev) || (err && err_prev)) viol++;
      rdy_prev = rdy;
      err_prev = err;
   end

   task automatic write_tx(input logic [15:0] d);
      @(negedge clk);
      tx_data = d;
      wrt_tx  = 1'b1;
      @(negedge clk);
      wrt_tx  = 1'b0;
      tx_model = d;
   endtask

   // wr_at: bit index for a mid-frame write, -2 writes on the slave's load cycle.
   task automatic do_frame(input logic [15:0] cmd, input int nbits, input int wr_at,
                           input logic [15:0] wr_data, input int rst_at,
                           output logic [15:0] rd, output int lat);
      rd  = '0;
      lat = 0;
      @(negedge clk);
      SS_n = 1'b0;
      if (wr_at == -2) begin
         repeat (3) @(negedge clk);
         tx_data = wr_data;
         wrt_tx  = 1'b1;
         @(negedge clk);
         wrt_tx  = 1'b0;
         repeat (28) @(negedge clk);
      end else begin
         repeat (32) @(negedge clk);
      end
      for (int i = 0; i < nbits; i++) begin
         SCLK = 1'b0;
         MOSI = cmd[15-i];
         if (i == wr_at) begin
            tx_data = wr_data;
            wrt_tx  = 1'b1;
            @(negedge clk);
            wrt_tx  = 1'b0;
            repeat (31) @(negedge clk);
         end else if (i == rst_at) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            repeat (31) @(negedge clk);
         end else begin
            repeat (32) @(negedge clk);
         end
         SCLK = 1'b1;
         rd = {rd[14:0], MISO};
         repeat (32) @(negedge clk);
      end
      SS_n = 1'b1;
      MOSI = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if ((rdy || err) && lat == 0) lat = k;
      end
      repeat (8) @(negedge clk);
   endtask

   task automatic good_frame(input string name, input logic [15:0] cmd,
                             input logic [15:0] exp_rd);
      logic [15:0] rd;
      int lat, r0, e0;
      r0 = rdy_cnt;
      e0 = err_cnt;
      exp_q.push_back(cmd);
      do_frame(cmd, 16, -1, 16'h0, -1, rd, lat);
      rx_model = cmd;
      n_cmp++;
      if (rd !== exp_rd) begin
         n_bad++;
         $display("FAIL %s_miso: got %h expected %h", name, rd, exp_rd);
      end
      n_cmp++;
      if (rdy_cnt - r0 !== 1 || err_cnt - e0 !== 0) begin
         n_bad++;
         $display("FAIL %s_pulses: rdy %0d err %0d expected 1/0", name, rdy_cnt - r0, err_cnt - e0);
      end
      n_cmp++;
      if (lat !== 4) begin
         n_bad++;
         $display("FAIL %s_latency: got %0d expected 4", name, lat);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({rdy, err, MISO} !== 3'b000 || rx_data !== 16'h0 || state !== 2'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: rdy=%b err=%b miso=%b rx=%h state=%0d expected 0s",
                  rdy, err, MISO, rx_data, state);
      end
      @(negedge clk);
      rst = 1'b0;
      tx_model = '0;
      rx_model = '0;
      repeat (10) @(negedge clk);
      good_frame("reset_buf", 16'h5A5A, 16'h0000);
   endtask

   task automatic test_paired();
      write_tx(16'hA5C3);
      good_frame("paired", 16'h1234, 16'hA5C3);
   endtask

   task automatic test_back_to_back();
      good_frame("b2b_ffff", 16'hFFFF, tx_model);
      good_frame("b2b_0000", 16'h0000, tx_model);
   endtask

   task automatic test_wrt_during_shift();
      logic [15:0] rd;
      int lat;
      write_tx(16'h1111);
      exp_q.push_back(16'h2468);
      do_frame(16'h2468, 16, 5, 16'hBEEF, -1, rd, lat);
      rx_model = 16'h2468;
      n_cmp++;
      if (rd !== 16'h1111) begin
         n_bad++;
         $display("FAIL midwrite_cur: got %h expected 1111", rd);
      end
      tx_model = 16'hBEEF;
      good_frame("midwrite_next", 16'h0F0F, 16'hBEEF);
   endtask

   task automatic test_wrt_on_fall();
      logic [15:0] rd, d;
      int lat;
      d = 16'($urandom_range(0, 65535));
      exp_q.push_back(16'h3C3C);
      do_frame(16'h3C3C, 16, -2, d, -1, rd, lat);
      tx_model = d;
      rx_model = 16'h3C3C;
      n_cmp++;
      if (rd !== d) begin
         n_bad++;
         $display("FAIL wrt_on_fall: got %h expected %h", rd, d);
      end
   endtask

   task automatic test_bad_frame(input string name, input int nbits);
      logic [15:0] rd;
      int lat, r0, e0;
      r0 = rdy_cnt;
      e0 = err_cnt;
      do_frame(16'hC3A5, nbits, -1, 16'h0, -1, rd, lat);
      n_cmp++;
      if (err_cnt - e0 !== 1 || rdy_cnt - r0 !== 0) begin
         n_bad++;
         $display("FAIL %s_pulses: err %0d rdy %0d expected 1/0", name, err_cnt - e0, rdy_cnt - r0);
      end
      n_cmp++;
      if (rx_data !== rx_model) begin
         n_bad++;
         $display("FAIL %s_rx_kept: got %h expected %h", name, rx_data, rx_model);
      end
      n_cmp++;
      if (lat !== 4) begin
         n_bad++;
         $display("FAIL %s_latency: got %0d expected 4", name, lat);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [15:0] rd;
      int lat, r0, e0;
      write_tx(16'h7777);
      r0 = rdy_cnt;
      e0 = err_cnt;
      do_frame(16'hFACE, 16, -1, 16'h0, 7, rd, lat);
      tx_model = '0;
      rx_model = '0;
      n_cmp++;
      if (rdy_cnt - r0 !== 0 || err_cnt - e0 !== 0) begin
         n_bad++;
         $display("FAIL rst_abort_pulses: rdy %0d err %0d expected 0/0", rdy_cnt - r0, err_cnt - e0);
      end
      n_cmp++;
      if (rx_data !== 16'h0) begin
         n_bad++;
         $display("FAIL rst_abort_rx: got %h expected 0000", rx_data);
      end
      good_frame("rst_recover", 16'h8001, 16'h0000);
   endtask

   task automatic test_idle_sclk();
      int r0, e0, bad;
      r0 = rdy_cnt;
      e0 = err_cnt;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         SCLK = ~SCLK;
         MOSI = 1'($urandom_range(0, 1));
         repeat (8) begin
            @(negedge clk);
            if (MISO !== 1'b0 || state !== 2'd0) bad++;
         end
      end
      n_cmp++;
      if (bad !== 0 || rdy_cnt - r0 !== 0 || err_cnt - e0 !== 0) begin
         n_bad++;
         $display("FAIL idle_sclk: %0d bad cycles, rdy %0d err %0d expected 0/0/0",
                  bad, rdy_cnt - r0, err_cnt - e0);
      end
      SCLK = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_random();
      for (int n = 0; n < 6; n++) begin
         if ($urandom_range(0, 1) == 1) write_tx(16'($urandom_range(0, 65535)));
         good_frame("random", 16'($urandom_range(0, 65535)), tx_model);
      end
   endtask

   initial begin
      test_reset();
      test_paired();
      test_back_to_back();
      test_wrt_during_shift();
      test_wrt_on_fall();
      test_bad_frame("short8", 8);
      test_bad_frame("no_sclk", 0);
      test_reset_mid_frame();
      test_idle_sclk();
      test_random();
      n_cmp++;
      if (exp_q.size() !== 0) begin
         n_bad++;
         $display("FAIL missing_rdy: %0d words never delivered, expected 0", exp_q.size());
      end
      n_cmp++;
      if (viol !== 0) begin
         n_bad++;
         $display("FAIL pulse_shape: %0d overlapping or long pulses, expected 0", viol);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
